alu_serial: RTL and testbench



---
 rtl/alu_serial.sv | 195 +++++++++++++++++++
 tb/tb_alu_serial.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial.sv
//==============================================================================
// Module   : alu_serial
// Brief    : Digit-serial six-op ALU (pass B/add/sub/AND/OR/XOR), one SLICE-bit
//            slice per cycle, with zero/negative/overflow/carry flags.
//            Optional macro ALU_SERIAL_EARLY_LOGIC_EN: non-arithmetic ops finish
//            in the accepting cycle and skip the serial pass.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module alu_serial #(
    parameter int WIDTH = 64,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             carryOut
);

    localparam int c_N  = WIDTH / SLICE;
    localparam int c_KW = (c_N > 1) ? $clog2(c_N) : 1;
    localparam int c_IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_PASSB = 3'b000;
    localparam logic [2:0] c_OP_ADD   = 3'b010;
    localparam logic [2:0] c_OP_SUB   = 3'b011;
    localparam logic [2:0] c_OP_AND   = 3'b100;
    localparam logic [2:0] c_OP_OR    = 3'b101;
    localparam logic [2:0] c_OP_XOR   = 3'b110;

    generate
        if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
            $error("alu_serial: WIDTH must be a positive multiple of SLICE");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_ctrl;
    logic [c_KW-1:0]  r_k;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_negative;
    logic             r_overflow;
    logic             r_carryOut;
    logic             r_outValid;

    logic [c_IW-1:0]  w_base;
    logic [SLICE-1:0] w_aSl;
    logic [SLICE-1:0] w_bSl;
    logic [SLICE-1:0] w_bEff;
    logic [SLICE:0]   w_sum;
    logic [SLICE-1:0] w_slice;
    logic             w_msbCin;
    logic             w_isArith;
    logic             w_isArithIn;
    logic             w_lastSlice;
    logic [WIDTH-1:0] w_nextResult;

    assign w_isArith   = (r_ctrl == c_OP_ADD) || (r_ctrl == c_OP_SUB);
    assign w_isArithIn = (ctrl == c_OP_ADD) || (ctrl == c_OP_SUB);
    assign w_lastSlice = (r_k == c_KW'(c_N - 1));
    assign w_base      = c_IW'(r_k) * c_IW'(SLICE);
    assign w_aSl       = r_a[w_base +: SLICE];
    assign w_bSl       = r_b[w_base +: SLICE];

    // Subtraction is A + ~B with the carry register preloaded to 1.
    always_comb begin
        w_bEff       = (r_ctrl == c_OP_SUB) ? ~w_bSl : w_bSl;
        w_sum        = {1'b0, w_aSl} + {1'b0, w_bEff} + {{SLICE{1'b0}}, r_carry};
        w_msbCin     = w_aSl[SLICE-1] ^ w_bEff[SLICE-1] ^ w_sum[SLICE-1];
        w_slice      = '0;
        case (r_ctrl)
            c_OP_PASSB:       w_slice = w_bSl;
            c_OP_ADD,
            c_OP_SUB:         w_slice = w_sum[SLICE-1:0];
            c_OP_AND:         w_slice = w_aSl & w_bSl;
            c_OP_OR:          w_slice = w_aSl | w_bSl;
            c_OP_XOR:         w_slice = w_aSl ^ w_bSl;
            default:          w_slice = '0;
        endcase
        w_nextResult                   = r_result;
        w_nextResult[w_base +: SLICE]  = w_slice;
    end

`ifdef ALU_SERIAL_EARLY_LOGIC_EN
    logic [WIDTH-1:0] w_fullLogic;

    always_comb begin
        w_fullLogic = '0;
        case (ctrl)
            c_OP_PASSB: w_fullLogic = B;
            c_OP_AND:   w_fullLogic = A & B;
            c_OP_OR:    w_fullLogic = A | B;
            c_OP_XOR:   w_fullLogic = A ^ B;
            default:    w_fullLogic = '0;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_ctrl     <= '0;
            r_k        <= '0;
            r_carry    <= 1'b0;
            r_result   <= '0;
            r_zero     <= 1'b0;
            r_negative <= 1'b0;
            r_overflow <= 1'b0;
            r_carryOut <= 1'b0;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a        <= A;
                        r_b        <= B;
                        r_ctrl     <= ctrl;
                        r_k        <= '0;
                        r_carry    <= w_isArithIn & ctrl[0];
                        r_zero     <= 1'b0;
                        r_negative <= 1'b0;
                        r_overflow <= 1'b0;
                        r_carryOut <= 1'b0;
`ifdef ALU_SERIAL_EARLY_LOGIC_EN
                        if (!w_isArithIn) begin
                            r_result   <= w_fullLogic;
                            r_zero     <= (w_fullLogic == '0);
                            r_negative <= w_fullLogic[WIDTH-1];
                            r_outValid <= 1'b1;
                            r_state    <= c_DONE;
                        end else begin
                            r_state    <= c_BUSY;
                        end
`else
                        r_state    <= c_BUSY;
`endif
                    end
                end
                c_BUSY: begin
                    r_result <= w_nextResult;
                    r_carry  <= w_sum[SLICE];
                    if (w_lastSlice) begin
                        r_zero     <= (w_nextResult == '0);
                        r_negative <= w_nextResult[WIDTH-1];
                        r_carryOut <= w_isArith & w_sum[SLICE];
                        r_overflow <= w_isArith & (w_msbCin ^ w_sum[SLICE]);
                        r_outValid <= 1'b1;
                        r_state    <= c_DONE;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == c_IDLE) && !reset;
    assign out_valid = r_outValid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign overflow  = r_overflow;
    assign carryOut  = r_carryOut;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
//==============================================================================
// Module   : tb_alu_serial
// Brief    : Self-checking bench for alu_serial (WIDTH=16, SLICE=4): vector
//            table, backpressure/reset sequences and random ops vs a model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_alu_serial;

    localparam int c_W = 16;
    localparam int c_S = 4;
    localparam int c_N = c_W / c_S;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [c_W-1:0] A;
    logic [c_W-1:0] B;
    logic [2:0]     ctrl;
    logic           out_valid;
    logic           out_ready;
    logic [c_W-1:0] result;
    logic           zero;
    logic           negative;
    logic           overflow;
    logic           carryOut;

    int total = 0;
    int bad   = 0;

    alu_serial #(.WIDTH(c_W), .SLICE(c_S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .carryOut  (carryOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  op;
        logic [15:0] res;
        logic [3:0]  fl;    // {zero, negative, overflow, carryOut}
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain two's-complement arithmetic on whole operands.
    function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [16:0] s;
        logic [15:0] r;
        logic        v;
        logic        c;
        s = '0; r = '0; v = 1'b0; c = 1'b0;
        case (op)
            3'b000: r = b;
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0];
                c = s[16];
                v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            3'b011: begin
                r = a - b;
                c = (a >= b);
                v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = '0;
        endcase
        return {r, (r == 16'h0), r[15], v, c};
    endfunction

    // Rising edges after the accepting edge until out_valid is seen.
    function automatic int expLat(input logic [2:0] op);
`ifdef ALU_SERIAL_EARLY_LOGIC_EN
        return (op == 3'b010 || op == 3'b011) ? c_N : 0;
`else
        return (op == 3'b010 || op == 3'b011) ? c_N : c_N;
`endif
    endfunction

    task automatic runOp(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                         output logic [15:0] res, output logic [3:0] fl, output int lat);
        int g;
        @(negedge clk);
        A = a; B = b; ctrl = op; in_valid = 1'b1; out_ready = 1'b1;
        g = 0;
        while (!in_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        fl  = {zero, negative, overflow, carryOut};
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] res;
        logic [3:0]  fl;
        logic [19:0] exp;
        int          lat;
        int          g;

        tbl[0]  = '{16'hFFFF, 16'h0001, 3'b010, 16'h0000, 4'b1001};
        tbl[1]  = '{16'h8000, 16'h0001, 3'b011, 16'h7FFF, 4'b0011};
        tbl[2]  = '{16'h0006, 16'h000A, 3'b011, 16'hFFFC, 4'b0100};
        tbl[3]  = '{16'h7FFF, 16'h0001, 3'b010, 16'h8000, 4'b0110};
        tbl[4]  = '{16'hFFFF, 16'hFFFF, 3'b010, 16'hFFFE, 4'b0101};
        tbl[5]  = '{16'hAAAA, 16'h5555, 3'b100, 16'h0000, 4'b1000};
        tbl[6]  = '{16'h1234, 16'h5678, 3'b111, 16'h0000, 4'b1000};
        tbl[7]  = '{16'h0000, 16'h9ABC, 3'b000, 16'h9ABC, 4'b0100};
        tbl[8]  = '{16'h00F0, 16'h0F00, 3'b101, 16'h0FF0, 4'b0000};
        tbl[9]  = '{16'hFFFF, 16'h00FF, 3'b110, 16'hFF00, 4'b0100};
        tbl[10] = '{16'hFFFF, 16'hFFFF, 3'b001, 16'h0000, 4'b1000};
        tbl[11] = '{16'h0005, 16'h0005, 3'b011, 16'h0000, 4'b1001};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; ctrl = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result",    {16'd0, result}, 32'd0);
        check("rst_flags",     {28'd0, zero, negative, overflow, carryOut}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            runOp(tbl[i].a, tbl[i].b, tbl[i].op, res, fl, lat);
            check($sformatf("tbl%0d_result", i), {16'd0, res}, {16'd0, tbl[i].res});
            check($sformatf("tbl%0d_flags", i),  {28'd0, fl}, {28'd0, tbl[i].fl});
            check($sformatf("tbl%0d_latency", i), lat, expLat(tbl[i].op));
        end

        // Backpressure: result held in DONE, second request waits for the drain.
        @(negedge clk);
        A = 16'h1234; B = 16'h1111; ctrl = 3'b010; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("bp_latency", g, c_N);
        @(negedge clk);
        A = 16'hFFFF; B = 16'h0001; ctrl = 3'b011; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid",  {31'd0, out_valid}, 32'd1);
            check("bp_hold_result", {16'd0, result}, 32'h2345);
            check("bp_hold_flags",  {28'd0, zero, negative, overflow, carryOut}, 32'd0);
            check("bp_hold_ready",  {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        check("bp_no_accept_on_drain", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
        check("bp2_latency", g, c_N);
        check("bp2_result", {16'd0, result}, 32'hFFFE);
        check("bp2_flags",  {28'd0, zero, negative, overflow, carryOut}, 32'b0101);
        @(posedge clk); #1;

        // Reset while slice k=2 of an add is in flight.
        @(negedge clk);
        A = 16'h0F0F; B = 16'h0101; ctrl = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result",    {16'd0, result}, 32'd0);
        check("midrst_in_ready",  {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("postrst_in_ready",  {31'd0, in_ready}, 32'd1);
        check("postrst_out_valid", {31'd0, out_valid}, 32'd0);
        runOp(16'h0F0F, 16'h0101, 3'b010, res, fl, lat);
        check("postrst_result",  {16'd0, res}, 32'h1010);
        check("postrst_flags",   {28'd0, fl}, 32'd0);
        check("postrst_latency", lat, c_N);

        for (int i = 0; i < 40; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic [2:0]  rop;
            ra  = 16'($urandom);
            rb  = (i % 8 == 0) ? ra : 16'($urandom);
            rop = 3'($urandom_range(0, 7));
            exp = model(ra, rb, rop);
            runOp(ra, rb, rop, res, fl, lat);
            check($sformatf("rnd%0d_result op=%0d", i, rop), {16'd0, res}, {16'd0, exp[19:4]});
            check($sformatf("rnd%0d_flags op=%0d", i, rop),  {28'd0, fl}, {28'd0, exp[3:0]});
            check($sformatf("rnd%0d_latency", i), lat, expLat(rop));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
